// File: rtl/sequenciador_pc_if.sv
// Control bundle between decode/imem/PC register and sequenciador_pc.
// slave = sequencer side, master = environment driving it.
interface sequenciador_pc_if #(
    parameter int LARGURA = 32
);
    logic               inicia;
    logic               instr_valida;
    logic               stall;
    logic [LARGURA-1:0] pc_atual;
    logic               hlt;
    logic               continua;
    logic               salto;
    logic               desvio;
    logic               chamada;
    logic               retorno;
    logic [LARGURA-1:0] alvo;
    logic               pc_jump;
    logic [LARGURA-1:0] pc_endereco;
    logic               pc_halt;
    logic               pc_reseta;
    logic [1:0]         estado;
    logic               erro_pilha;

    modport master (
        output inicia, instr_valida, stall, pc_atual, hlt, continua,
        output salto, desvio, chamada, retorno, alvo,
        input  pc_jump, pc_endereco, pc_halt, pc_reseta, estado, erro_pilha
    );

    modport slave (
        input  inicia, instr_valida, stall, pc_atual, hlt, continua,
        input  salto, desvio, chamada, retorno, alvo,
        output pc_jump, pc_endereco, pc_halt, pc_reseta, estado, erro_pilha
    );
endinterface

// File: rtl/sequenciador_pc.sv
// Fetch/execute sequencer driving PC jump/halt/reset controls.
// Define RAS_EN to include the return-address stack.
module sequenciador_pc #(
    parameter int LARGURA      = 32,
    parameter int PROFUNDIDADE = 8
) (
    input logic              clock,
    input logic              reseta,
    sequenciador_pc_if.slave bus
);
    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        BUSCA   = 2'b01,
        EXECUTA = 2'b10,
        PARADO  = 2'b11
    } estado_t;

    estado_t            estado_q, estado_d;
    logic               para_q, para_d;
    logic               jump_q, jump_d;
    logic               halt_q, halt_d;
    logic               rst_q, rst_d;
    logic [LARGURA-1:0] end_q, end_d;

`ifdef RAS_EN
    localparam int PW = $clog2(PROFUNDIDADE);

    logic [PW:0]        sp_q, sp_d;
    logic [LARGURA-1:0] pilha [PROFUNDIDADE];
    logic               push;
    logic [PW-1:0]      topo;
    logic               cheia;
    logic               erro_q, erro_d;

    assign topo  = sp_q[PW-1:0] - 1'b1;
    assign cheia = (sp_q == (PW+1)'(PROFUNDIDADE));
`endif

    always_comb begin
        estado_d = estado_q;
        para_d   = para_q;
        jump_d   = 1'b0;
        halt_d   = 1'b1;
        rst_d    = 1'b0;
        end_d    = end_q;
`ifdef RAS_EN
        sp_d     = sp_q;
        push     = 1'b0;
        erro_d   = erro_q;
`endif
        unique case (estado_q)
            OCIOSO: begin
                rst_d = 1'b1;
                if (bus.inicia) begin
                    estado_d = BUSCA;
                    rst_d    = 1'b0;
                end
            end
            BUSCA: begin
                if (bus.instr_valida && !bus.stall) begin
                    estado_d = EXECUTA;
                    para_d   = 1'b0;
                    if (bus.hlt) begin
                        para_d = 1'b1;
                    end else if (bus.retorno) begin
`ifdef RAS_EN
                        if (sp_q == '0) begin
                            para_d = 1'b1;
                            erro_d = 1'b1;
                        end else begin
                            jump_d = 1'b1;
                            halt_d = 1'b0;
                            end_d  = pilha[topo];
                            sp_d   = sp_q - 1'b1;
                        end
`else
                        para_d = 1'b1;
`endif
                    end else if (bus.chamada) begin
                        jump_d = 1'b1;
                        halt_d = 1'b0;
                        end_d  = bus.alvo;
`ifdef RAS_EN
                        // full stack: jump anyway, drop the return address
                        if (cheia) begin
                            erro_d = 1'b1;
                        end else begin
                            push = 1'b1;
                            sp_d = sp_q + 1'b1;
                        end
`endif
                    end else if (bus.salto || bus.desvio) begin
                        jump_d = 1'b1;
                        halt_d = 1'b0;
                        end_d  = bus.alvo;
                    end else begin
                        halt_d = 1'b0;
                    end
                end
            end
            EXECUTA: begin
                estado_d = para_q ? PARADO : BUSCA;
            end
            PARADO: begin
                if (bus.continua) begin
                    estado_d = EXECUTA;
                    para_d   = 1'b0;
                    halt_d   = 1'b0;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge reseta) begin
        if (!reseta) begin
            estado_q <= OCIOSO;
            para_q   <= 1'b0;
            jump_q   <= 1'b0;
            halt_q   <= 1'b1;
            rst_q    <= 1'b1;
            end_q    <= '0;
`ifdef RAS_EN
            sp_q     <= '0;
            erro_q   <= 1'b0;
`endif
        end else begin
            estado_q <= estado_d;
            para_q   <= para_d;
            jump_q   <= jump_d;
            halt_q   <= halt_d;
            rst_q    <= rst_d;
            end_q    <= end_d;
`ifdef RAS_EN
            sp_q     <= sp_d;
            erro_q   <= erro_d;
`endif
        end
    end

`ifdef RAS_EN
    always_ff @(posedge clock) begin
        if (push) begin
            pilha[sp_q[PW-1:0]] <= bus.pc_atual + 1'b1;
        end
    end

    assign bus.erro_pilha = erro_q;
`else
    assign bus.erro_pilha = 1'b0;
`endif

    assign bus.estado      = estado_q;
    assign bus.pc_jump     = jump_q;
    assign bus.pc_halt     = halt_q;
    assign bus.pc_reseta   = rst_q;
    assign bus.pc_endereco = end_q;
endmodule

// File: tb/tb_sequenciador_pc.sv
// Scoreboard bench for sequenciador_pc: queued expectations from a
// queue-based reference model, checked by a monitor in EXECUTA.
module tb_sequenciador_pc;
    localparam int W    = 32;
    localparam int PROF = 8;

    logic clock = 1'b0;
    logic reseta = 1'b0;
    always #5 clock = ~clock;

    sequenciador_pc_if #(.LARGURA(W)) bus ();

    sequenciador_pc #(
        .LARGURA      (W),
        .PROFUNDIDADE (PROF)
    ) dut (
        .clock  (clock),
        .reseta (reseta),
        .bus    (bus)
    );

    typedef struct {
        logic          jump;
        logic [W-1:0]  ende;
        logic          chk_end;
        logic          halt;
        logic          erro;
        logic          parou;
    } exp_t;

    exp_t         exp_q [$];
    logic [W-1:0] pilha_m [$];
    logic         erro_m = 1'b0;
    int           nerr = 0;
    int           nchk = 0;

    function automatic void chk(string nome, logic [31:0] atual, logic [31:0] exigido);
        nchk++;
        if (atual !== exigido) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, atual, exigido, $time);
        end
    endfunction

    // Reference: next-PC decision straight from the priority rules
    function automatic exp_t modelo(logic h, logic r, logic c, logic s, logic d,
                                    logic [W-1:0] a, logic [W-1:0] p);
        exp_t e;
        e.jump = 1'b0; e.ende = '0; e.chk_end = 1'b0;
        e.halt = 1'b0; e.parou = 1'b0;
        if (h) begin
            e.halt = 1'b1; e.parou = 1'b1;
        end else if (r) begin
`ifdef RAS_EN
            if (pilha_m.size() == 0) begin
                e.halt = 1'b1; e.parou = 1'b1; erro_m = 1'b1;
            end else begin
                e.jump = 1'b1; e.chk_end = 1'b1; e.ende = pilha_m.pop_back();
            end
`else
            e.halt = 1'b1; e.parou = 1'b1;
`endif
        end else if (c) begin
            e.jump = 1'b1; e.chk_end = 1'b1; e.ende = a;
`ifdef RAS_EN
            if (pilha_m.size() == PROF) erro_m = 1'b1;
            else pilha_m.push_back(p + 32'd1);
`endif
        end else if (s || d) begin
            e.jump = 1'b1; e.chk_end = 1'b1; e.ende = a;
        end
        e.erro = erro_m;
        return e;
    endfunction

    always @(negedge clock) begin
        if (reseta && bus.estado == 2'b10) begin
            if (exp_q.size() == 0) begin
                nchk++; nerr++;
                $display("FAIL exec_unexpected: EXECUTA with empty queue at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ex_jump", bus.pc_jump, e.jump);
                chk("ex_halt", bus.pc_halt, e.halt);
                chk("ex_erro", bus.erro_pilha, e.erro);
                chk("ex_reseta", bus.pc_reseta, 1'b0);
                if (e.chk_end) chk("ex_endereco", bus.pc_endereco, e.ende);
            end
        end
    end

    task automatic limpa();
        bus.inicia = 0; bus.instr_valida = 0; bus.stall = 0; bus.hlt = 0;
        bus.continua = 0; bus.salto = 0; bus.desvio = 0; bus.chamada = 0;
        bus.retorno = 0;
    endtask

    task automatic lixo();
        bus.inicia = 1'($urandom); bus.instr_valida = 1'($urandom);
        bus.stall = 1'($urandom); bus.hlt = 1'($urandom);
        bus.continua = 1'($urandom); bus.salto = 1'($urandom);
        bus.desvio = 1'($urandom); bus.chamada = 1'($urandom);
        bus.retorno = 1'($urandom); bus.alvo = $urandom; bus.pc_atual = $urandom;
    endtask

    task automatic esperar_busca();
        int n = 0;
        while (bus.estado != 2'b01 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (bus.estado != 2'b01) begin
            nchk++; nerr++;
            $display("FAIL wait_busca: estado=%b expected 01", bus.estado);
        end
    endtask

    task automatic executa(input logic h, input logic r, input logic c,
                           input logic s, input logic d,
                           input logic [W-1:0] a, input logic [W-1:0] p,
                           input int nst, output logic parou);
        exp_t e;
        esperar_busca();
        bus.hlt = h; bus.retorno = r; bus.chamada = c;
        bus.salto = s; bus.desvio = d; bus.alvo = a; bus.pc_atual = p;
        bus.instr_valida = 1'b1; bus.stall = (nst > 0);
        for (int i = 0; i < nst; i++) begin
            @(negedge clock);
            chk("stall_estado", bus.estado, 2'b01);
            chk("stall_halt", bus.pc_halt, 1'b1);
            chk("stall_jump", bus.pc_jump, 1'b0);
        end
        bus.stall = 1'b0;
        e = modelo(h, r, c, s, d, a, p);
        exp_q.push_back(e);
        parou = e.parou;
        @(posedge clock);
        #1 lixo();
        @(negedge clock);
        @(negedge clock);
        limpa();
        chk("post_estado", bus.estado, parou ? 2'b11 : 2'b01);
        chk("post_jump", bus.pc_jump, 1'b0);
        chk("post_halt", bus.pc_halt, 1'b1);
    endtask

    task automatic retoma();
        exp_t e;
        bus.continua = 1'b1;
        e.jump = 1'b0; e.ende = '0; e.chk_end = 1'b0;
        e.halt = 1'b0; e.erro = erro_m; e.parou = 1'b0;
        exp_q.push_back(e);
        @(posedge clock);
        #1 bus.continua = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("resume_estado", bus.estado, 2'b01);
        chk("resume_halt", bus.pc_halt, 1'b1);
    endtask

    task automatic partida();
        bus.inicia = 1'b1;
        @(posedge clock);
        #1 bus.inicia = 1'b0;
        @(negedge clock);
        chk("start_estado", bus.estado, 2'b01);
        chk("start_reseta", bus.pc_reseta, 1'b0);
        chk("start_halt", bus.pc_halt, 1'b1);
    endtask

    initial begin
        logic p;
        logic ras;
`ifdef RAS_EN
        ras = 1'b1;
`else
        ras = 1'b0;
`endif
        limpa();
        bus.alvo = '0; bus.pc_atual = '0;
        repeat (2) @(negedge clock);
        chk("rst_estado", bus.estado, 2'b00);
        chk("rst_reseta", bus.pc_reseta, 1'b1);
        chk("rst_halt", bus.pc_halt, 1'b1);
        chk("rst_jump", bus.pc_jump, 1'b0);
        chk("rst_endereco", bus.pc_endereco, 32'h0);
        chk("rst_erro", bus.erro_pilha, 1'b0);
        reseta = 1'b1;
        @(negedge clock);
        chk("idle_estado", bus.estado, 2'b00);
        chk("idle_reseta", bus.pc_reseta, 1'b1);
        partida();

        executa(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, p);
        executa(0, 0, 0, 0, 0, 32'h0, 32'h1, 0, p);
        executa(0, 0, 0, 1, 1, 32'h40, 32'h2, 0, p);
        executa(1, 0, 0, 1, 0, 32'h77, 32'h3, 0, p);
        bus.inicia = 1'b1;
        @(negedge clock);
        bus.inicia = 1'b0;
        chk("parado_ignora_inicia", bus.estado, 2'b11);
        retoma();

        executa(0, 0, 1, 0, 0, 32'h80, 32'h10, 0, p);
        executa(0, 1, 0, 0, 0, 32'h0, 32'h80, 0, p);
        if (p) retoma();

        for (int i = 0; i < 9; i++) begin
            executa(0, 0, 1, 0, 0, 32'h100 * (i + 1), 32'(i), 0, p);
        end
        chk("overflow_erro", bus.erro_pilha, ras);

        executa(0, 0, 0, 0, 0, 32'h0, 32'h50, 5, p);

        esperar_busca();
        bus.salto = 1'b1; bus.alvo = 32'hABC; bus.instr_valida = 1'b1;
        @(posedge clock);
        #2 reseta = 1'b0;
        #1;
        chk("arst_estado", bus.estado, 2'b00);
        chk("arst_jump", bus.pc_jump, 1'b0);
        chk("arst_reseta", bus.pc_reseta, 1'b1);
        chk("arst_erro", bus.erro_pilha, 1'b0);
        chk("arst_endereco", bus.pc_endereco, 32'h0);
        pilha_m.delete();
        erro_m = 1'b0;
        limpa();
        @(negedge clock);
        reseta = 1'b1;
        @(negedge clock);
        partida();

        executa(0, 1, 0, 0, 0, 32'h0, 32'h20, 0, p);
        chk("underflow_estado", bus.estado, 2'b11);
        chk("underflow_erro", bus.erro_pilha, ras);
        retoma();

        executa(0, 0, 0, 0, 0, 32'h0, 32'hFFFF_FFFF, 0, p);
        executa(0, 0, 1, 0, 0, 32'h300, 32'hFFFF_FFFF, 0, p);
        executa(0, 1, 0, 0, 0, 32'h0, 32'h300, 0, p);
        if (p) retoma();

        for (int i = 0; i < 150; i++) begin
            logic h, r, c, s, d;
            h = ($urandom_range(0, 15) == 0);
            r = ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 3) == 0);
            executa(h, r, c, s, d, $urandom, $urandom, $urandom_range(0, 2), p);
            if (p) retoma();
        end

        repeat (2) @(negedge clock);
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/sequenciador_pc.md
Name: sequenciador_pc

Overview:
- Fetch/execute sequencer that drives the program counter's control inputs (jump, target address, halt, reset).
- Waits for instruction-memory acknowledge and selects next-PC action: advance, jump, branch, call, return, halt.
- Owns an optional return-address stack.
- Sits between decode, instruction memory and the PC register.

Parameters:
LARGURA, 32, address width of PC and targets
PROFUNDIDADE, 8, return-address stack entries (power of 2, >=2)

Ports:
clock  in  1  system clock, rising edge
reseta  in  1  asynchronous active-low reset
inicia  in  1  start pulse; leaves OCIOSO
instr_valida  in  1  instruction memory ack for current pc_atual
stall  in  1  hold in BUSCA even if instr_valida
pc_atual  in  LARGURA  current PC value
hlt  in  1  decoded halt instruction
continua  in  1  resume from PARADO
salto  in  1  unconditional jump
desvio  in  1  branch taken
chamada  in  1  call (jump + push)
retorno  in  1  return (pop + jump)
alvo  in  LARGURA  target for salto/desvio/chamada
pc_jump  out  1  load pc_endereco into PC
pc_endereco  out  LARGURA  target address
pc_halt  out  1  hold PC
pc_reseta  out  1  synchronous clear to PC (active-high)
estado  out  2  00 OCIOSO, 01 BUSCA, 10 EXECUTA, 11 PARADO
erro_pilha  out  1  sticky stack overflow/underflow flag

Behaviour:
- Reset (reseta=0, async): state OCIOSO; pc_reseta=1, pc_halt=1, pc_jump=0, pc_endereco=0, erro_pilha=0, stack pointer=0. All outputs are registered.
- OCIOSO: pc_reseta=1, pc_halt=1. On inicia=1 -> BUSCA with pc_reseta=0.
- BUSCA: pc_halt=1, pc_jump=0. If instr_valida=1 and stall=0, decide the action and -> EXECUTA. Otherwise stay. No timeout.
- Decision priority: hlt > retorno > chamada > salto > desvio > advance.
- EXECUTA: lasts exactly 1 cycle, with outputs set per the decision:
  - advance: pc_halt=0, pc_jump=0.
  - salto/desvio: pc_jump=1, pc_endereco=alvo.
  - chamada: pc_jump=1, pc_endereco=alvo; push pc_atual+1 (mod 2^LARGURA).
  - retorno: pc_jump=1, pc_endereco=top of stack; pop.
  - hlt: pc_halt=1, pc_jump=0; next state PARADO instead of BUSCA.
- Then -> BUSCA with pc_jump=0, pc_halt=1. The PC therefore changes exactly once per executed instruction, at the end of EXECUTA.
- PARADO: pc_halt=1. On continua=1 -> EXECUTA with advance (PC steps past HLT). inicia is ignored.
- Stack overflow (chamada when full): jump still taken, push discarded, erro_pilha=1.
- Stack underflow (retorno when empty): treated as hlt -> PARADO, erro_pilha=1.
- erro_pilha clears only on reset.
- Control inputs are sampled only in BUSCA at the decision edge; they are ignored in other states.
- Reset asserted mid-EXECUTA: the PC update is aborted (pc_reseta=1), and stack contents are considered invalid.

Optional Feature:
RAS_EN:
- Defined: return-address stack present, as described above.
- Undefined: no stack storage. chamada behaves as salto. retorno behaves as hlt (-> PARADO). erro_pilha is tied to 0.

Test Plan:
- Reset, then inicia, instr_valida held 1 -> pc_reseta falls; pc_halt toggles 1,0 each 2 cycles; estado alternates 01/10.
- Priority: instr_valida with salto=1, desvio=1, alvo=0x40 -> pc_jump=1, pc_endereco=0x40 for exactly one cycle. Then hlt=1 with salto=1 -> PARADO, pc_jump=0. continua -> one advance cycle.
- RAS_EN defined, pc_atual=0x10, chamada alvo=0x80, then retorno -> pc_endereco=0x80, then 0x11. 9 nested calls with PROFUNDIDADE=8 -> erro_pilha=1 on the 9th, jump still taken.
- retorno with empty stack -> estado=11, erro_pilha=1. Without RAS_EN -> estado=11, erro_pilha=0.
- stall=1 with instr_valida=1 for 5 cycles -> stays in BUSCA, pc_halt=1, no PC change. stall drops -> EXECUTA next cycle.
- reseta pulled low mid-EXECUTA during a jump -> estado=00, pc_jump=0, pc_reseta=1 immediately without a clock edge, erro_pilha=0.
